// File: rtl/bus_arbiter.sv
// Bus arbiter sharing the CPU address/data bus with one DMA/debug master.
// All state advances on bus_ce ticks; the bus mux follows the state combinationally.
module bus_arbiter #(
    parameter int HOLD_LAT  = 2,
    parameter int MAX_BURST = 16,
    parameter int CPU_MIN   = 4
) (
    input  logic        clk_in,
    input  logic        b_reset,
    input  logic        bus_ce,
    input  logic [15:0] cpu_ad,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_rw,
    input  logic        cpu_vma,
    output logic        cpu_hold,
    input  logic        dma_req,
    input  logic [15:0] dma_ad,
    input  logic [7:0]  dma_do,
    input  logic        dma_rw,
    input  logic        dma_vma,
    output logic        dma_gnt,
    output logic        dma_ack,
    output logic [7:0]  dma_di,
    input  logic [7:0]  bus_di,
    output logic [15:0] bus_ad,
    output logic [7:0]  bus_do,
    output logic        bus_rw,
    output logic        bus_vma
);

    localparam int HW = $clog2(HOLD_LAT) + 1;
    localparam int MW = $clog2(CPU_MIN) + 1;
    localparam int BW = $clog2(MAX_BURST) + 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_LAT - 1);
    localparam logic [MW-1:0] MIN_TICKS = MW'(CPU_MIN);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    typedef enum logic [1:0] {
        CPU_OWN,
        HOLD,
        DMA_OWN,
        RELEASE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;
    logic [MW-1:0] cpu_min_cnt;
    logic [MW-1:0] min_nxt;
    logic [MW-1:0] min_inc;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_nxt;
    logic [BW-1:0] burst_inc;

    logic          cpu_hold_nxt;
    logic          dma_gnt_nxt;
    logic          dma_ack_nxt;
    logic [7:0]    dma_di_nxt;

    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            state       <= CPU_OWN;
            hold_cnt    <= '0;
            cpu_min_cnt <= MIN_TICKS;
            burst_cnt   <= '0;
            cpu_hold    <= 1'b0;
            dma_gnt     <= 1'b0;
            dma_ack     <= 1'b0;
            dma_di      <= 8'h00;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            cpu_min_cnt <= min_nxt;
            burst_cnt   <= burst_nxt;
            cpu_hold    <= cpu_hold_nxt;
            dma_gnt     <= dma_gnt_nxt;
            dma_ack     <= dma_ack_nxt;
            dma_di      <= dma_di_nxt;
        end
    end

    always_comb begin
        if (cpu_min_cnt >= MIN_TICKS) begin
            min_inc = cpu_min_cnt;
        end else begin
            min_inc = cpu_min_cnt + MW'(1);
        end
        burst_inc = burst_cnt + BW'(dma_vma);
    end

    // Eligibility uses the post-increment count so the CPU gets exactly
    // CPU_MIN owned ticks after a release before the next hold.
    always_comb begin
        state_nxt    = state;
        hold_nxt     = hold_cnt;
        min_nxt      = cpu_min_cnt;
        burst_nxt    = burst_cnt;
        cpu_hold_nxt = cpu_hold;
        dma_gnt_nxt  = dma_gnt;
        dma_ack_nxt  = 1'b0;
        dma_di_nxt   = dma_di;
        if (bus_ce) begin
            unique case (state)
                CPU_OWN: begin
                    min_nxt = min_inc;
                    if (dma_req && (min_inc >= MIN_TICKS)) begin
                        state_nxt    = HOLD;
                        cpu_hold_nxt = 1'b1;
                        hold_nxt     = '0;
                    end
                end
                HOLD: begin
                    hold_nxt = hold_cnt + HW'(1);
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt   = DMA_OWN;
                        dma_gnt_nxt = 1'b1;
                        burst_nxt   = '0;
                    end
                end
                DMA_OWN: begin
                    burst_nxt = burst_inc;
                    if (dma_vma) begin
                        dma_ack_nxt = 1'b1;
                        if (dma_rw) begin
                            dma_di_nxt = bus_di;
                        end
                    end
                    if (!dma_req || (burst_inc >= BURST_MAX)) begin
                        state_nxt   = RELEASE;
                        dma_gnt_nxt = 1'b0;
                    end
                end
                RELEASE: begin
                    state_nxt    = CPU_OWN;
                    cpu_hold_nxt = 1'b0;
                    min_nxt      = '0;
                end
                default: begin
                    state_nxt = CPU_OWN;
                end
            endcase
        end
    end

    // HOLD and RELEASE park the bus on an idle read cycle.
    always_comb begin
        bus_ad  = cpu_ad;
        bus_do  = cpu_do;
        bus_rw  = 1'b1;
        bus_vma = 1'b0;
        unique case (state)
            CPU_OWN: begin
                bus_rw  = cpu_rw;
                bus_vma = cpu_vma;
            end
            DMA_OWN: begin
                bus_ad  = dma_ad;
                bus_do  = dma_do;
                bus_rw  = dma_rw;
                bus_vma = dma_vma;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every clock against a phase model.
module tb_bus_arbiter;

    localparam int HOLD_LAT  = 2;
    localparam int MAX_BURST = 16;
    localparam int CPU_MIN   = 4;

    logic        clk_in  = 1'b0;
    logic        b_reset = 1'b0;
    logic        bus_ce  = 1'b0;
    logic [15:0] cpu_ad  = 16'h0000;
    logic [7:0]  cpu_do  = 8'h00;
    logic        cpu_rw  = 1'b1;
    logic        cpu_vma = 1'b0;
    logic        cpu_hold;
    logic        dma_req = 1'b0;
    logic [15:0] dma_ad  = 16'h0000;
    logic [7:0]  dma_do  = 8'h00;
    logic        dma_rw  = 1'b1;
    logic        dma_vma = 1'b0;
    logic        dma_gnt;
    logic        dma_ack;
    logic [7:0]  dma_di;
    logic [7:0]  bus_di  = 8'h00;
    logic [15:0] bus_ad;
    logic [7:0]  bus_do;
    logic        bus_rw;
    logic        bus_vma;

    bus_arbiter #(
        .HOLD_LAT (HOLD_LAT),
        .MAX_BURST(MAX_BURST),
        .CPU_MIN  (CPU_MIN)
    ) dut (
        .clk_in  (clk_in),
        .b_reset (b_reset),
        .bus_ce  (bus_ce),
        .cpu_ad  (cpu_ad),
        .cpu_do  (cpu_do),
        .cpu_rw  (cpu_rw),
        .cpu_vma (cpu_vma),
        .cpu_hold(cpu_hold),
        .dma_req (dma_req),
        .dma_ad  (dma_ad),
        .dma_do  (dma_do),
        .dma_rw  (dma_rw),
        .dma_vma (dma_vma),
        .dma_gnt (dma_gnt),
        .dma_ack (dma_ack),
        .dma_di  (dma_di),
        .bus_di  (bus_di),
        .bus_ad  (bus_ad),
        .bus_do  (bus_do),
        .bus_rw  (bus_rw),
        .bus_vma (bus_vma)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errs   = 0;
    bit ack_first;
    bit ack_after;

    // Model: phase derived from (m_hold, m_gnt, m_rel); counters are ticks
    // owned by the CPU, HOLD ticks still to wait, and burst cycles remaining.
    int         age;
    int         hold_left;
    int         burst_left;
    bit         m_hold;
    bit         m_gnt;
    bit         m_rel;
    bit         m_ack;
    logic [7:0] m_di;
    logic [15:0] e_ad;
    logic [7:0]  e_do;
    logic        e_rw;
    logic        e_vma;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        age        = CPU_MIN;
        hold_left  = 0;
        burst_left = 0;
        m_hold     = 1'b0;
        m_gnt      = 1'b0;
        m_rel      = 1'b0;
        m_ack      = 1'b0;
        m_di       = 8'h00;
    endtask

    task automatic m_tick();
        m_ack = 1'b0;
        if (bus_ce) begin
            if (!m_hold) begin
                if (dma_req && (age + 1 >= CPU_MIN)) begin
                    m_hold    = 1'b1;
                    hold_left = HOLD_LAT;
                end
                age = (age + 1 > CPU_MIN) ? CPU_MIN : age + 1;
            end else if (m_rel) begin
                m_rel  = 1'b0;
                m_hold = 1'b0;
                age    = 0;
            end else if (m_gnt) begin
                if (dma_vma) begin
                    burst_left--;
                    m_ack = 1'b1;
                    if (dma_rw) m_di = bus_di;
                end
                if (!dma_req || burst_left == 0) begin
                    m_gnt = 1'b0;
                    m_rel = 1'b1;
                end
            end else begin
                hold_left--;
                if (hold_left == 0) begin
                    m_gnt      = 1'b1;
                    burst_left = MAX_BURST;
                end
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk_in or negedge b_reset);
            if (!b_reset) m_reset();
            else m_tick();
            #1;
            if (!m_hold) begin
                e_ad = cpu_ad; e_do = cpu_do;
                e_rw = cpu_rw; e_vma = cpu_vma;
            end else if (m_gnt) begin
                e_ad = dma_ad; e_do = dma_do;
                e_rw = dma_rw; e_vma = dma_vma;
            end else begin
                e_ad = cpu_ad; e_do = cpu_do;
                e_rw = 1'b1; e_vma = 1'b0;
            end
            chk("m_cpu_hold", 16'(cpu_hold), 16'(m_hold));
            chk("m_dma_gnt", 16'(dma_gnt), 16'(m_gnt));
            chk("m_dma_ack", 16'(dma_ack), 16'(m_ack));
            chk("m_dma_di", 16'(dma_di), 16'(m_di));
            chk("m_bus_ad", bus_ad, e_ad);
            chk("m_bus_do", 16'(bus_do), 16'(e_do));
            chk("m_bus_rw", 16'(bus_rw), 16'(e_rw));
            chk("m_bus_vma", 16'(bus_vma), 16'(e_vma));
        end
    end

    task automatic step(input int gap);
        bus_ce = 1'b1;
        @(negedge clk_in);
        bus_ce    = 1'b0;
        ack_first = dma_ack;
        ack_after = dma_ack;
        repeat (gap) @(negedge clk_in);
        if (gap > 0) ack_after = dma_ack;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        b_reset = 1'b0;
        bus_ce  = 1'b0;
        dma_req = 1'b0;
        dma_vma = 1'b0;
        @(negedge clk_in);
        b_reset = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int n_ack;
        repeat (2) @(negedge clk_in);
        b_reset = 1'b1;
        chk("rst_hold", 16'(cpu_hold), 16'd0);
        chk("rst_gnt", 16'(dma_gnt), 16'd0);
        chk("rst_ack", 16'(dma_ack), 16'd0);
        chk("rst_di", 16'(dma_di), 16'd0);

        cpu_ad = 16'hF000; cpu_rw = 1'b1; cpu_vma = 1'b1; cpu_do = 8'h11;
        for (int i = 0; i < 5; i++) begin
            step(0);
            chk("t1_bus_ad", bus_ad, 16'hF000);
            chk("t1_bus_vma", 16'(bus_vma), 16'd1);
            chk("t1_hold", 16'(cpu_hold), 16'd0);
            chk("t1_gnt", 16'(dma_gnt), 16'd0);
        end

        dma_req = 1'b1; dma_ad = 16'h0010; dma_do = 8'h5A;
        dma_rw = 1'b0; dma_vma = 1'b1;
        step(0);
        chk("t2_hold_t1", 16'(cpu_hold), 16'd1);
        chk("t2_vma_t1", 16'(bus_vma), 16'd0);
        chk("t2_gnt_t1", 16'(dma_gnt), 16'd0);
        step(0);
        chk("t2_vma_t2", 16'(bus_vma), 16'd0);
        chk("t2_gnt_t2", 16'(dma_gnt), 16'd0);
        step(0);
        chk("t2_gnt_t3", 16'(dma_gnt), 16'd1);
        chk("t2_bus_ad", bus_ad, 16'h0010);
        chk("t2_bus_do", 16'(bus_do), 16'h005A);
        chk("t2_bus_rw", 16'(bus_rw), 16'd0);
        chk("t2_bus_vma", 16'(bus_vma), 16'd1);

        n_ack = 0;
        for (int i = 0; i < 20; i++) begin
            step(0);
            if (ack_first) n_ack++;
            if (!dma_gnt) break;
        end
        chk("t3_acks", 16'(n_ack), 16'd16);
        chk("t3_rel_gnt", 16'(dma_gnt), 16'd0);
        chk("t3_rel_hold", 16'(cpu_hold), 16'd1);
        step(0);
        chk("t3_cpu_hold", 16'(cpu_hold), 16'd0);
        n = 0;
        for (int i = 0; i < 10 && !cpu_hold; i++) begin
            step(0);
            n++;
        end
        chk("t3_cpu_min", 16'(n), 16'd4);

        step(0);
        step(0);
        chk("t4_gnt", 16'(dma_gnt), 16'd1);
        dma_ad = 16'hE6A0; dma_rw = 1'b1; dma_vma = 1'b1; bus_di = 8'hC3;
        step(0);
        chk("t4_ack", 16'(ack_first), 16'd1);
        chk("t4_di", 16'(dma_di), 16'h00C3);
        dma_req = 1'b0; dma_vma = 1'b0;
        step(0);
        chk("t4_rel_gnt", 16'(dma_gnt), 16'd0);
        chk("t4_rel_hold", 16'(cpu_hold), 16'd1);
        step(0);
        chk("t4_cpu_hold", 16'(cpu_hold), 16'd0);

        do_reset();
        dma_req = 1'b1; dma_rw = 1'b0; dma_vma = 1'b0;
        repeat (3) step(0);
        chk("t5_gnt", 16'(dma_gnt), 16'd1);
        dma_vma = 1'b1;
        repeat (7) step(0);
        chk("t5_gnt7", 16'(dma_gnt), 16'd1);
        cpu_ad = 16'h1234;
        #2 b_reset = 1'b0;
        #1;
        chk("t5_async_hold", 16'(cpu_hold), 16'd0);
        chk("t5_async_gnt", 16'(dma_gnt), 16'd0);
        chk("t5_async_ack", 16'(dma_ack), 16'd0);
        chk("t5_async_ad", bus_ad, 16'h1234);
        @(negedge clk_in);
        b_reset = 1'b1; dma_vma = 1'b0;
        step(0);
        chk("t5_rehold", 16'(cpu_hold), 16'd1);
        chk("t5_regnt0", 16'(dma_gnt), 16'd0);
        step(0);
        step(0);
        chk("t5_regnt", 16'(dma_gnt), 16'd1);

        do_reset();
        dma_req = 1'b1; dma_vma = 1'b0;
        step(3);
        chk("t6_hold", 16'(cpu_hold), 16'd1);
        chk("t6_gnt_a", 16'(dma_gnt), 16'd0);
        step(3);
        chk("t6_gnt_b", 16'(dma_gnt), 16'd0);
        step(3);
        chk("t6_gnt_c", 16'(dma_gnt), 16'd1);
        dma_vma = 1'b1; dma_rw = 1'b1; bus_di = 8'h77;
        step(3);
        chk("t6_ack_on", 16'(ack_first), 16'd1);
        chk("t6_ack_off", 16'(ack_after), 16'd0);
        chk("t6_di", 16'(dma_di), 16'h0077);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            if ($urandom_range(0, 7) == 0) dma_req = ~dma_req;
            cpu_ad  = 16'($urandom);
            cpu_do  = 8'($urandom);
            cpu_rw  = 1'($urandom);
            cpu_vma = 1'($urandom);
            dma_ad  = 16'($urandom);
            dma_do  = 8'($urandom);
            dma_rw  = 1'($urandom);
            dma_vma = ($urandom_range(0, 3) != 0);
            bus_di  = 8'($urandom);
            step(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the CPU address/data bus (boot ROM, RAM, simple I/O, UART decoders) between the cpu68 core and one DMA/debug master.
- Sits between the CPU pins and the address decoders.
- Stalls the CPU through its hold input, grants the bus to the DMA master for a bounded burst, then returns it.
- All state advances only on bus clock-enable ticks, so the block runs on clk_in with bus_ce marking each CPU bus cycle.

Parameters:
- HOLD_LAT, 2: bus_ce ticks between asserting cpu_hold and granting the DMA master (CPU freeze latency).
- MAX_BURST, 16: maximum DMA bus cycles with dma_vma=1 per grant.
- CPU_MIN, 4: minimum bus_ce ticks the CPU owns the bus after a release, before the next hold.

Ports:
- clk_in in 1: system oscillator clock.
- b_reset in 1: asynchronous, active-low reset.
- bus_ce in 1: one-clk_in-wide pulse per bus cycle; all state updates are qualified by it.
- cpu_ad in 16: CPU address.
- cpu_do in 8: CPU write data.
- cpu_rw in 1: CPU read/write, 1 = read.
- cpu_vma in 1: CPU valid memory address.
- cpu_hold out 1: hold request to the CPU.
- dma_req in 1: DMA master requests the bus (level).
- dma_ad in 16: DMA address.
- dma_do in 8: DMA write data.
- dma_rw in 1: DMA read/write, 1 = read.
- dma_vma in 1: DMA access valid this bus cycle.
- dma_gnt out 1: DMA owns the bus.
- dma_ack out 1: one-clk_in pulse when a DMA access completes.
- dma_di out 8: read data captured for the DMA master.
- bus_di in 8: read data from the decoder mux.
- bus_ad out 16: shared address.
- bus_do out 8: shared write data.
- bus_rw out 1: shared read/write.
- bus_vma out 1: shared valid.

Behaviour:
- Reset is asynchronous, b_reset low. Outputs at reset: state=CPU_OWN, cpu_hold=0, dma_gnt=0, dma_ack=0, dma_di=0. cpu_min_cnt is set to CPU_MIN so a request is eligible immediately. hold_cnt=0, burst_cnt=0.
- Bus mux is combinational from state:
  - CPU_OWN: bus_* = cpu_*.
  - DMA_OWN: bus_* = dma_*.
  - HOLD and RELEASE: bus_ad = cpu_ad, bus_do = cpu_do, bus_rw = 1, bus_vma = 0. No access occurs.
- Only clk_in edges with bus_ce=1 advance state or counters. dma_ack is the only exception: it clears on the next clk_in edge.
- CPU_OWN:
  - cpu_min_cnt increments, saturating at CPU_MIN.
  - If dma_req=1 and cpu_min_cnt>=CPU_MIN: go to HOLD, cpu_hold<=1, hold_cnt<=0.
- HOLD:
  - hold_cnt increments.
  - When hold_cnt==HOLD_LAT-1: go to DMA_OWN, dma_gnt<=1, burst_cnt<=0.
  - If dma_req falls while in HOLD: complete HOLD anyway, then go DMA_OWN → RELEASE on the next tick. No abort path.
- DMA_OWN:
  - On each tick with dma_vma=1: burst_cnt++, dma_ack<=1 for one clk_in cycle.
  - If also dma_rw=1: dma_di<=bus_di.
  - Exit when dma_req=0, or when burst_cnt reaches MAX_BURST after this tick's count. Both conditions in the same tick cause a single transition.
  - On exit: go to RELEASE, dma_gnt<=0.
- RELEASE: one tick, then CPU_OWN with cpu_hold<=0 and cpu_min_cnt<=0.
- Latency from dma_req sampled high (CPU eligible) to first DMA bus cycle: 1+HOLD_LAT ticks.
- Counter widths: hold_cnt and cpu_min_cnt use clog2 of their parameter + 1; burst_cnt uses clog2(MAX_BURST)+1. Counters never wrap; they saturate or reset as stated above.
- dma_gnt and cpu_hold are never both 0 while in HOLD, DMA_OWN or RELEASE. cpu_hold=1 throughout those states.
- Reset mid-burst: immediate return to the reset values above; the bus reverts to the CPU combinationally.
- bus_ce held low: all state is frozen, outputs are stable and the mux is unchanged.

Test Plan:
1. Reset, no dma_req, CPU drives ad=$F000 rw=1 vma=1 → bus_ad=$F000, bus_vma=1, cpu_hold=0, dma_gnt=0 every tick.
2. dma_req=1 at tick 0 with HOLD_LAT=2:
   - cpu_hold=1 from tick 1, bus_vma=0 on ticks 1-2.
   - dma_gnt=1 at tick 3; DMA write ad=$0010 do=$5A appears on bus_* at tick 3.
3. DMA holds dma_req with dma_vma=1 for 20 cycles, MAX_BURST=16:
   - Exactly 16 dma_ack pulses, then RELEASE for 1 tick.
   - CPU owns the bus for 4 ticks (CPU_MIN) before cpu_hold re-asserts.
4. DMA read of $E6A0 with bus_di=$C3 → dma_di=$C3 and dma_ack pulse on the same ce edge. dma_req dropped next tick → RELEASE, then CPU_OWN.
5. b_reset pulled low in DMA_OWN at burst_cnt=7 → cpu_hold=0, dma_gnt=0 and bus_ad=cpu_ad without waiting for any clock edge. After release, a dma_req sequence restarts from HOLD.
6. Toggle bus_ce only every 4th clk_in while in HOLD → state advances only on ce pulses. dma_ack width is 1 clk_in.
